conv_window_feeder: RTL and testbench
=====================================

// Module: conv_window_feeder
// PURPOSE
//  Upstream stage of the 3x3 convolution engine. It loads the kernel, then turns a raster
//  pixel stream into zero-padded 3-pixel vertical columns using two internal line buffers.
//  Drives the engine's data_in0/1/2, valid_in, kernel_load and valid_out (win_valid)
//  inputs for a same-size (PADDING=1, STRIDE=1) convolution of one image per start.
// PARAMETERS
//  DATA_WIDTH  16  bits per pixel / weight
//  IMG_WIDTH   28  pixels per image row (W), >=2
//  IMG_HEIGHT  28  rows per image (H), >=2
// PORTS
//  clk          in   1        clock
//  rst          in   1        asynchronous, active-high reset
//  start        in   1        pulse: begin kernel load + one image; ignored unless IDLE
//  kernel_col   in   3*DW     kernel column beat {K[2][i],K[1][i],K[0][i]}, i=beat 0..2
//  kernel_valid in   1        kernel_col valid
//  kernel_ready out  1        high in KLOAD
//  pix_in       in   DW       raster pixel, row-major, top-left first
//  pix_valid    in   1        pix_in valid
//  pix_ready    out  1        transfer = pix_valid & pix_ready
//  data_out0    out  DW       column top element (window row 0)
//  data_out1    out  DW       column middle element
//  data_out2    out  DW       column bottom element
//  col_valid    out  1        column/kernel beat valid (-> engine valid_in)
//  kernel_load  out  1        current beat is kernel data (-> engine kernel_load)
//  win_valid    out  1        engine window complete; latch result (-> engine valid_out)
//  busy         out  1        state != IDLE
//  done         out  1        one-cycle pulse after the last window of the image
// BEHAVIOUR
//  - Reset (async): state IDLE; all outputs 0; row/col counters 0. Line-buffer RAM is not
//    cleared. Top padding comes from a row==0 mux, never from stale buffer contents.
//  - FSM states: IDLE -> KLOAD -> PRIME -> ROW -> IDLE.
//    IDLE: start moves to KLOAD.
//    KLOAD: each kernel_valid beat is accepted. After the 3rd beat, go to PRIME.
//    PRIME: pix_ready=1. Accept W pixels (image row 0) into lb_cur. Then go to ROW with r=0.
//    ROW: emit columns k=0..W+1 for output row r. When k=W+1 has been emitted, r++.
//      When r reaches H, return to IDLE.
//  - Outputs are registered. An accepted kernel beat or column appears on data_out* with
//    col_valid=1 on the next cycle. kernel_load=1 only for kernel beats.
//    Kernel beat i maps data_out_j = K[j][i].
//  - Column k of row r is {data_out2,data_out1,data_out0} = {P[r+1][k-1], P[r][k-1], P[r-1][k-1]}.
//    Any out-of-range index (k==0, k==W+1, r==0 top, r==H-1 bottom) gives 0.
//  - Interior columns (1<=k<=W) with r<H-1 need one input pixel P[r+1][k-1]. pix_ready=1 there.
//    With no transfer the column is stalled: col_valid=0 and k is held.
//    Padding columns and every column of row H-1 consume no pixel. pix_ready=0 there and
//    those columns emit every cycle.
//  - Line-buffer update on column k-1 consume: lb_prev[k-1]<=lb_cur[k-1]; lb_cur[k-1]<=pix.
//    For row H-1, lb_prev<=lb_cur still shifts, with no write of a new pixel.
//  - win_valid is registered: it is asserted the cycle after col_valid for a column with k>=2.
//    That gives exactly W win_valid pulses per row and W*H per image, in raster order.
//  - done pulses the cycle after the final win_valid. busy falls in the same cycle.
//  - start while busy: ignored. kernel_valid outside KLOAD: ignored. pix_ready=0 in IDLE/KLOAD.
//  - Counters: k is clog2(W+2) bits, wraps to 0 at the end of a row. r is clog2(H+1) bits.
// TESTING (W=H=4 unless noted)
//  - Kernel load: start, 3 beats {3,2,1},{6,5,4},{9,8,7} -> 3 col_valid+kernel_load cycles,
//    data_out0 = 1,4,7 in order; kernel_ready=0 afterwards.
//  - Full image, pixels P=1..16, continuous valid -> 24 col_valid (6/row), 16 win_valid.
//    Row 0 column 1 = {5,1,0}; row 3 column 4 = {0,16,12}; columns 0 and 5 are all-zero.
//  - Random pix_valid gaps (50%) -> column sequence identical to the previous test.
//    col_valid never high on a stalled cycle.
//  - pix_ready=0 for all of row 3. A pixel offered during row 3 is not consumed.
//    done pulses once and busy drops in the same cycle.
//  - Assert rst mid-row 1 -> all outputs 0 immediately. A new start with a new image gives
//    correct columns (top row zero despite stale buffers).
//  - start pulsed during ROW -> no effect. W=2,H=2 build -> 8 columns, 4 win_valid.

Source files
------------

// File: rtl/conv_window_feeder.sv
// Front end of the 3x3 convolution engine: loads the kernel, then turns a raster pixel
// stream into zero-padded vertical 3-pixel columns using two line buffers.
module conv_window_feeder #(
   parameter int DATA_WIDTH = 16,
   parameter int IMG_WIDTH  = 28,
   parameter int IMG_HEIGHT = 28
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [3*DATA_WIDTH-1:0] kernel_col,
   input  logic                    kernel_valid,
   output logic                    kernel_ready,
   input  logic [DATA_WIDTH-1:0]   pix_in,
   input  logic                    pix_valid,
   output logic                    pix_ready,
   output logic [DATA_WIDTH-1:0]   data_out0,
   output logic [DATA_WIDTH-1:0]   data_out1,
   output logic [DATA_WIDTH-1:0]   data_out2,
   output logic                    col_valid,
   output logic                    kernel_load,
   output logic                    win_valid,
   output logic                    busy,
   output logic                    done
);

   localparam int KW = $clog2(IMG_WIDTH + 2);
   localparam int RW = $clog2(IMG_HEIGHT + 1);
   localparam int AW = $clog2(IMG_WIDTH);
   localparam logic [KW-1:0] K_LAST       = KW'(IMG_WIDTH + 1);
   localparam logic [KW-1:0] K_PRIME_LAST = KW'(IMG_WIDTH - 1);
   localparam logic [KW-1:0] K_BEAT_LAST  = KW'(2);
   localparam logic [RW-1:0] R_LAST       = RW'(IMG_HEIGHT - 1);

   typedef enum logic [1:0] {S_IDLE, S_KLOAD, S_PRIME, S_ROW} state_t;

   state_t                state_q, state_d;
   logic [KW-1:0]         k_q, k_d;
   logic [RW-1:0]         r_q, r_d;
   logic [DATA_WIDTH-1:0] data0_q, data0_d, data1_q, data1_d, data2_q, data2_d;
   logic                  col_valid_q, col_valid_d;
   logic                  kernel_load_q, kernel_load_d;
   logic                  win_pend_q, win_pend_d;
   logic                  win_valid_q, win_valid_d;
   logic                  last_col_q, last_col_d;
   logic                  last_win_q, last_win_d;
   logic                  done_q, done_d;
   logic                  busy_q, busy_d;

   logic [DATA_WIDTH-1:0] lb_prev_q [IMG_WIDTH];
   logic [DATA_WIDTH-1:0] lb_cur_q  [IMG_WIDTH];
   logic                  lb_shift, lb_wr;
   logic [AW-1:0]         lb_widx, rd_idx;

   logic pad, last_row, need_pix, pix_xfer;

   assign pad          = (k_q == '0) || (k_q == K_LAST);
   assign last_row     = (r_q == R_LAST);
   assign need_pix     = (state_q == S_ROW) && !pad && !last_row;
   assign pix_ready    = (state_q == S_PRIME) || need_pix;
   assign kernel_ready = (state_q == S_KLOAD);
   assign pix_xfer     = pix_valid && pix_ready;
   assign rd_idx       = AW'(k_q - KW'(1));

   always_comb begin
      state_d       = state_q;
      k_d           = k_q;
      r_d           = r_q;
      data0_d       = data0_q;
      data1_d       = data1_q;
      data2_d       = data2_q;
      col_valid_d   = 1'b0;
      kernel_load_d = 1'b0;
      win_pend_d    = 1'b0;
      win_valid_d   = win_pend_q;
      last_col_d    = 1'b0;
      last_win_d    = last_col_q;
      done_d        = last_win_q;
      lb_shift      = 1'b0;
      lb_wr         = 1'b0;
      lb_widx       = rd_idx;
      case (state_q)
         S_IDLE: begin
            // busy_q still high while the last window drains out of the pipeline
            if (start && !busy_q) begin
               state_d = S_KLOAD;
               k_d     = '0;
            end
         end
         S_KLOAD: begin
            if (kernel_valid) begin
               col_valid_d   = 1'b1;
               kernel_load_d = 1'b1;
               data0_d       = kernel_col[DATA_WIDTH-1:0];
               data1_d       = kernel_col[2*DATA_WIDTH-1:DATA_WIDTH];
               data2_d       = kernel_col[3*DATA_WIDTH-1:2*DATA_WIDTH];
               if (k_q == K_BEAT_LAST) begin
                  k_d     = '0;
                  state_d = S_PRIME;
               end else begin
                  k_d = k_q + 1'b1;
               end
            end
         end
         S_PRIME: begin
            if (pix_xfer) begin
               lb_wr   = 1'b1;
               lb_widx = AW'(k_q);
               if (k_q == K_PRIME_LAST) begin
                  k_d     = '0;
                  r_d     = '0;
                  state_d = S_ROW;
               end else begin
                  k_d = k_q + 1'b1;
               end
            end
         end
         S_ROW: begin
            if (!need_pix || pix_xfer) begin
               col_valid_d = 1'b1;
               data0_d     = (pad || r_q == '0) ? '0 : lb_prev_q[rd_idx];
               data1_d     = pad ? '0 : lb_cur_q[rd_idx];
               data2_d     = (pad || last_row) ? '0 : pix_in;
               win_pend_d  = (k_q >= KW'(2));
               if (!pad) begin
                  lb_shift = 1'b1;
                  lb_wr    = !last_row;
               end
               if (k_q == K_LAST) begin
                  k_d = '0;
                  r_d = r_q + 1'b1;
                  if (last_row) begin
                     state_d    = S_IDLE;
                     last_col_d = 1'b1;
                  end
               end else begin
                  k_d = k_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE) || last_col_d || last_win_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         k_q           <= '0;
         r_q           <= '0;
         data0_q       <= '0;
         data1_q       <= '0;
         data2_q       <= '0;
         col_valid_q   <= 1'b0;
         kernel_load_q <= 1'b0;
         win_pend_q    <= 1'b0;
         win_valid_q   <= 1'b0;
         last_col_q    <= 1'b0;
         last_win_q    <= 1'b0;
         done_q        <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         k_q           <= k_d;
         r_q           <= r_d;
         data0_q       <= data0_d;
         data1_q       <= data1_d;
         data2_q       <= data2_d;
         col_valid_q   <= col_valid_d;
         kernel_load_q <= kernel_load_d;
         win_pend_q    <= win_pend_d;
         win_valid_q   <= win_valid_d;
         last_col_q    <= last_col_d;
         last_win_q    <= last_win_d;
         done_q        <= done_d;
         busy_q        <= busy_d;
      end
   end

   // Line buffers are plain RAM; top padding is muxed, so no reset is needed here
   always_ff @(posedge clk) begin
      if (lb_shift) lb_prev_q[lb_widx] <= lb_cur_q[lb_widx];
      if (lb_wr)    lb_cur_q[lb_widx]  <= pix_in;
   end

   assign data_out0   = data0_q;
   assign data_out1   = data1_q;
   assign data_out2   = data2_q;
   assign col_valid   = col_valid_q;
   assign kernel_load = kernel_load_q;
   assign win_valid   = win_valid_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench for conv_window_feeder: 4x4 instance for kernel/stream/stall/reset cases,
// plus a 2x2 instance for the minimum-size image.
module tb_conv_window_feeder;

   localparam int W = 4;
   localparam int H = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, kernel_valid, pix_valid;
   logic [47:0] kernel_col;
   logic [15:0] pix_in;
   logic        kernel_ready, pix_ready, col_valid, kernel_load, win_valid, busy, done;
   logic [15:0] data_out0, data_out1, data_out2;

   logic        b_start, b_kernel_valid, b_pix_valid;
   logic [47:0] b_kernel_col;
   logic [15:0] b_pix_in;
   logic        b_kernel_ready, b_pix_ready, b_col_valid, b_kernel_load, b_win_valid;
   logic        b_busy, b_done;
   logic [15:0] b_data_out0, b_data_out1, b_data_out2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   conv_window_feeder #(.DATA_WIDTH(16), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk(clk), .rst(rst), .start(start), .kernel_col(kernel_col),
      .kernel_valid(kernel_valid), .kernel_ready(kernel_ready), .pix_in(pix_in),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .data_out0(data_out0),
      .data_out1(data_out1), .data_out2(data_out2), .col_valid(col_valid),
      .kernel_load(kernel_load), .win_valid(win_valid), .busy(busy), .done(done)
   );

   conv_window_feeder #(.DATA_WIDTH(16), .IMG_WIDTH(2), .IMG_HEIGHT(2)) dut_b (
      .clk(clk), .rst(rst), .start(b_start), .kernel_col(b_kernel_col),
      .kernel_valid(b_kernel_valid), .kernel_ready(b_kernel_ready), .pix_in(b_pix_in),
      .pix_valid(b_pix_valid), .pix_ready(b_pix_ready), .data_out0(b_data_out0),
      .data_out1(b_data_out1), .data_out2(b_data_out2), .col_valid(b_col_valid),
      .kernel_load(b_kernel_load), .win_valid(b_win_valid), .busy(b_busy), .done(b_done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Pixel (rr, k-1) of an image whose raster pixels are base+1, base+2, ...
   function automatic logic [15:0] colv(input int base, input int r, input int k, input int j);
      int rr;
      if (k == 0 || k == W + 1) return 16'd0;
      rr = r - 1 + j;
      if (rr < 0 || rr >= H) return 16'd0;
      return 16'(base + rr * W + k);
   endfunction

   task automatic load_kernel();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("kload_ready", kernel_ready, 1);
      chk("kload_busy", busy, 1);
      chk("kload_pix_ready", pix_ready, 0);
      for (int i = 0; i < 3; i++) begin
         kernel_valid = 1'b1;
         kernel_col   = {16'(3 * i + 3), 16'(3 * i + 2), 16'(3 * i + 1)};
         tick();
         chk("kbeat_valid", col_valid, 1);
         chk("kbeat_kload", kernel_load, 1);
         chk("kbeat_d0", data_out0, 3 * i + 1);
         chk("kbeat_d1", data_out1, 3 * i + 2);
         chk("kbeat_d2", data_out2, 3 * i + 3);
      end
      kernel_valid = 1'b0;
      chk("kload_ready_after", kernel_ready, 0);
   endtask

   task automatic run_image(input int base, input bit gaps, input int abort_row, input bit poke);
      int  phase, r, k, pi, pk, nwin, ncol_obs, nwin_obs;
      bit  needs, rdy, xfer, emit, pv, exp_win, prev_win, last_flag, exp_done, finished;
      phase = 0; r = 0; k = 0; pi = 0; pk = 0; nwin = 0; ncol_obs = 0; nwin_obs = 0;
      prev_win = 0; last_flag = 0; finished = 0;
      for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
         if (phase == 1 && r == abort_row && k == 2) return;
         pv        = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
         pix_valid = pv;
         pix_in    = (pi < W * H) ? 16'(base + pi + 1) : 16'hBEEF;
         start     = poke && phase == 1 && r == 1 && k == 0;
         needs     = phase == 1 && k >= 1 && k <= W && r < H - 1;
         rdy       = (phase == 0) || needs;
         chk("pix_ready", pix_ready, rdy);
         xfer      = pv && rdy;
         emit      = phase == 1 && (!needs || xfer);
         exp_done  = last_flag;
         exp_win   = prev_win;
         prev_win  = emit && k >= 2;
         if (exp_win) nwin++;
         last_flag = exp_win && nwin == W * H;
         tick();
         start = 1'b0;
         chk("col_valid", col_valid, emit);
         chk("win_valid", win_valid, exp_win);
         chk("done", done, exp_done);
         chk("busy", busy, !exp_done);
         if (col_valid) ncol_obs++;
         if (win_valid) nwin_obs++;
         if (emit) begin
            chk("col_d0", data_out0, colv(base, r, k, 0));
            chk("col_d1", data_out1, colv(base, r, k, 1));
            chk("col_d2", data_out2, colv(base, r, k, 2));
            chk("col_kload", kernel_load, 0);
            if (base == 0 && r == 0 && k == 1)
               chk("r0c1", {data_out2, data_out1, data_out0}, 48'h0005_0001_0000);
            if (base == 0 && r == 3 && k == 4)
               chk("r3c4", {data_out2, data_out1, data_out0}, 48'h0000_0010_000C);
         end
         if (exp_done) finished = 1;
         if (phase == 0) begin
            if (xfer) begin
               pi++; pk++;
               if (pk == W) begin phase = 1; r = 0; k = 0; end
            end
         end else if (emit) begin
            if (needs) pi++;
            if (k == W + 1) begin
               k = 0; r++;
               if (r == H) phase = 2;
            end else begin
               k++;
            end
         end
      end
      pix_valid = 1'b0;
      chk("image_finished", finished, 1);
      chk("col_count", ncol_obs, (W + 2) * H);
      chk("win_count", nwin_obs, W * H);
      tick();
      chk("done_single_pulse", done, 0);
      chk("busy_after", busy, 0);
   endtask

   initial begin
      logic [47:0] bcol [8];
      int  bpi, nb, nw;
      bit  bdone;
      rst = 1'b1; start = 1'b0; kernel_valid = 1'b0; pix_valid = 1'b0;
      kernel_col = '0; pix_in = '0;
      b_start = 1'b0; b_kernel_valid = 1'b0; b_pix_valid = 1'b0;
      b_kernel_col = '0; b_pix_in = '0;
      repeat (3) tick();
      chk("rst_col_valid", col_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_win_valid", win_valid, 0);
      chk("rst_kernel_ready", kernel_ready, 0);
      chk("rst_pix_ready", pix_ready, 0);
      chk("rst_data", {data_out2, data_out1, data_out0}, 0);
      chk("rst_b_busy", b_busy, 0);
      rst = 1'b0;
      tick();

      kernel_valid = 1'b1;
      kernel_col   = {16'd9, 16'd8, 16'd7};
      tick();
      kernel_valid = 1'b0;
      chk("idle_kvalid_ignored", col_valid, 0);

      load_kernel();
      run_image(0, 1'b0, -1, 1'b0);

      load_kernel();
      run_image(0, 1'b1, -1, 1'b1);

      load_kernel();
      run_image(0, 1'b0, 1, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("arst_col_valid", col_valid, 0);
      chk("arst_data", {data_out2, data_out1, data_out0}, 0);
      chk("arst_busy", busy, 0);
      chk("arst_pix_ready", pix_ready, 0);
      pix_valid = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      load_kernel();
      run_image(100, 1'b0, -1, 1'b0);

      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      chk("b_kernel_ready", b_kernel_ready, 1);
      for (int i = 0; i < 3; i++) begin
         b_kernel_valid = 1'b1;
         b_kernel_col   = {16'(3 * i + 3), 16'(3 * i + 2), 16'(3 * i + 1)};
         tick();
         chk("b_kbeat_kload", b_kernel_load, 1);
      end
      b_kernel_valid = 1'b0;
      bpi = 0; nb = 0; nw = 0; bdone = 0;
      for (int c = 0; c < 100 && !bdone; c++) begin
         b_pix_valid = 1'b1;
         b_pix_in    = (bpi < 4) ? 16'(bpi + 1) : 16'hBEEF;
         if (b_pix_ready) bpi++;
         tick();
         if (b_col_valid) begin
            if (nb < 8) bcol[nb] = {b_data_out2, b_data_out1, b_data_out0};
            nb++;
         end
         if (b_win_valid) nw++;
         if (b_done) bdone = 1;
      end
      b_pix_valid = 1'b0;
      chk("b_done_seen", bdone, 1);
      chk("b_col_count", nb, 8);
      chk("b_win_count", nw, 4);
      chk("b_col0", bcol[0], 0);
      chk("b_col1", bcol[1], 48'h0003_0001_0000);
      chk("b_col3", bcol[3], 0);
      chk("b_col6", bcol[6], 48'h0000_0004_0002);
      chk("b_busy_end", b_busy, 0);
      chk("b_kernel_ready_end", b_kernel_ready, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
